// File: rtl/belt_pkg.sv
// Shared definitions for the belt merge packer and the upstream quality sorter.
package belt_pkg;

  // Default width of one goods quality value.
  localparam int GOODS_W = 7;

  // Quality split point used by the sorter (>= threshold goes to belt A).
  localparam int QUALITY_THRESHOLD = 61;

  typedef logic [GOODS_W-1:0] goods_t;

  typedef enum logic {
    BELT_A = 1'b0,
    BELT_B = 1'b1
  } belt_id_e;

  // Round-robin pick: a lone requester wins; with both requesting, the belt
  // opposite to the last grant wins.
  function automatic belt_id_e rr_pick(input logic req_a,
                                       input logic req_b,
                                       input belt_id_e last_grant);
    belt_id_e pick;
    if (req_a && req_b) begin
      pick = (last_grant == BELT_A) ? BELT_B : BELT_A;
    end else if (req_b) begin
      pick = BELT_B;
    end else begin
      pick = BELT_A;
    end
    return pick;
  endfunction

endpackage

// File: rtl/belt_fifo.sv
// Synchronous FIFO for one belt. A push at full is accepted only when the
// same edge also pops; otherwise the item is not written (the caller flags it).
// The read port is combinational from storage: no write-to-read bypass.
module belt_fifo #(
  parameter int DATA_W = 7,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update on accepted push / pop.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  // NOTE: the array has no reset; empty pointers make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/belt_merge_packer.sv
// Merges the high-quality (A) and low-quality (B) belts onto one packing port.
// Each belt is buffered in its own FIFO; a round-robin arbiter feeds a single
// output register with a valid/ready handshake. Box positions are tracked per
// belt, the item closing a box is flagged, and completed boxes are counted.
module belt_merge_packer
  import belt_pkg::*;
#(
  parameter int DATA_W     = 7,
  parameter int FIFO_DEPTH = 4,
  parameter int BOX_SIZE   = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_belt_a,
  input  logic [DATA_W-1:0] belt_a,
  input  logic              valid_belt_b,
  input  logic [DATA_W-1:0] belt_b,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] goods_o,
  output logic              belt_id_o,
  output logic              box_last_o,
  output logic              ovf_a,
  output logic              ovf_b,
  output logic [CNT_W-1:0]  boxes_a,
  output logic [CNT_W-1:0]  boxes_b
);

  localparam logic [0:0] OUT_EMPTY = 1'b0;
  localparam logic [0:0] OUT_FULL  = 1'b1;

  // Position counters need at least one bit even when BOX_SIZE is 1.
  localparam int              POS_W    = (BOX_SIZE > 1) ? $clog2(BOX_SIZE) : 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(BOX_SIZE - 1);

  logic [DATA_W-1:0] a_rdata;
  logic [DATA_W-1:0] b_rdata;
  logic              a_full;
  logic              a_empty;
  logic              b_full;
  logic              b_empty;
  logic              pop_a;
  logic              pop_b;

  logic [0:0]        out_state;
  belt_id_e          out_id;
  belt_id_e          last_grant;
  belt_id_e          grant;
  logic              handshake;
  logic              load;
  logic              load_last;

  logic [POS_W-1:0]  pos_a;
  logic [POS_W-1:0]  pos_b;
  logic [POS_W-1:0]  pos_a_next;
  logic [POS_W-1:0]  pos_b_next;

  belt_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo_a (
    .clk   (clk),
    .rst   (rst),
    .push  (valid_belt_a),
    .wdata (belt_a),
    .pop   (pop_a),
    .rdata (a_rdata),
    .full  (a_full),
    .empty (a_empty)
  );

  belt_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo_b (
    .clk   (clk),
    .rst   (rst),
    .push  (valid_belt_b),
    .wdata (belt_b),
    .pop   (pop_b),
    .rdata (b_rdata),
    .full  (b_full),
    .empty (b_empty)
  );

  assign valid_o   = (out_state == OUT_FULL);
  assign belt_id_o = out_id;
  assign handshake = valid_o && ready_i;

  // Arbitration and load decision: load when the register is empty or is
  // being drained this edge, and some FIFO has an item.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    load  = 1'b0;
    grant = BELT_A;
    pop_a = 1'b0;
    pop_b = 1'b0;
    grant = rr_pick(!a_empty, !b_empty, last_grant);
    load  = (!a_empty || !b_empty) && ((out_state == OUT_EMPTY) || handshake);
    pop_a = load && (grant == BELT_A);
    pop_b = load && (grant == BELT_B);
  end

  // Post-handshake box positions. A reload of the same belt on a handshake
  // edge must see the advanced position, so box_last is derived from these.
  always_comb begin
    pos_a_next = pos_a;
    pos_b_next = pos_b;
    if (handshake && (out_id == BELT_A)) begin
      pos_a_next = (pos_a == LAST_POS) ? '0 : pos_a + POS_W'(1);
    end
    if (handshake && (out_id == BELT_B)) begin
      pos_b_next = (pos_b == LAST_POS) ? '0 : pos_b + POS_W'(1);
    end
    load_last = (grant == BELT_A) ? (pos_a_next == LAST_POS)
                                  : (pos_b_next == LAST_POS);
  end

  // Output register and round-robin pointer; pointer moves only on a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_state  <= OUT_EMPTY;
      goods_o    <= '0;
      out_id     <= BELT_A;
      box_last_o <= 1'b0;
      last_grant <= BELT_B;
    end else if (load) begin
      out_state  <= OUT_FULL;
      goods_o    <= (grant == BELT_A) ? a_rdata : b_rdata;
      out_id     <= grant;
      box_last_o <= load_last;
      last_grant <= grant;
    end else if (handshake) begin
      out_state  <= OUT_EMPTY;
    end
  end

  // Box positions and completed-box counters advance only on a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_a   <= '0;
      pos_b   <= '0;
      boxes_a <= '0;
      boxes_b <= '0;
    end else begin
      pos_a <= pos_a_next;
      pos_b <= pos_b_next;
      if (handshake && box_last_o && (out_id == BELT_A)) boxes_a <= boxes_a + 1'b1;
      if (handshake && box_last_o && (out_id == BELT_B)) boxes_b <= boxes_b + 1'b1;
    end
  end

  // Sticky overflow: an item arrives at a full FIFO that is not popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_a <= 1'b0;
      ovf_b <= 1'b0;
    end else begin
      if (valid_belt_a && a_full && !pop_a) ovf_a <= 1'b1;
      if (valid_belt_b && b_full && !pop_b) ovf_b <= 1'b1;
    end
  end

endmodule
